// File: rtl/flex_counter_mode.sv
// flex_counter_mode: up/down counter with wrap or saturate behaviour, parallel
// load, a registered terminal-value flag, a one-cycle wrap pulse and a
// saturating tally of wrap events. All outputs are registered.
module flex_counter_mode #(
    parameter int SIZE   = 4,
    parameter int WRAP_W = 4
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              restart,
    input  logic              clear,
    input  logic              load,
    input  logic [SIZE-1:0]   load_val,
    input  logic              count_enable,
    input  logic              up_down,
    input  logic              saturate,
    input  logic [SIZE-1:0]   rollover_val,
    output logic [SIZE-1:0]   count_out,
    output logic              rollover_flag,
    output logic              rollover_pulse,
    output logic [WRAP_W-1:0] wrap_count
);

    localparam logic [SIZE-1:0]   ONE       = SIZE'(1);
    localparam logic [SIZE-1:0]   ZERO      = '0;
    localparam logic [WRAP_W-1:0] TALLY_MAX = '1;

    logic [SIZE-1:0]   r_count;
    logic              r_flag;
    logic              r_pulse;
    logic [WRAP_W-1:0] r_tally;

    logic [SIZE-1:0]   w_terminal;
    logic [SIZE-1:0]   w_step_count;
    logic              w_step_wrap;
    logic [SIZE-1:0]   w_next_count;
    logic              w_next_flag;
    logic              w_next_pulse;
    logic [WRAP_W-1:0] w_next_tally;

    // Terminal value: rollover_val when counting up, 1 when counting down.
    assign w_terminal = up_down ? rollover_val : ONE;

    // One enabled counting step, before priority resolution.
    // A zero rollover_val disables counting entirely.
    always_comb begin
        w_step_count = r_count;
        w_step_wrap  = 1'b0;
        if (rollover_val != ZERO) begin
            if (up_down) begin
                if (r_count >= rollover_val) begin
                    // At or beyond terminal: wrap to 1, or hold when saturating
                    if (!saturate) begin
                        w_step_count = ONE;
                        w_step_wrap  = 1'b1;
                    end
                end else begin
                    w_step_count = r_count + ONE;
                end
            end else begin
                if (r_count == ONE) begin
                    // Reached 1: reload, or hold when saturating
                    if (!saturate) begin
                        w_step_count = rollover_val;
                        w_step_wrap  = 1'b1;
                    end
                end else if ((r_count == ZERO) || (r_count > rollover_val)) begin
                    // Out-of-range count re-enters at the top without an event
                    w_step_count = rollover_val;
                end else begin
                    w_step_count = r_count - ONE;
                end
            end
        end
    end

    // Priority: restart > clear > load > count_enable > hold.
    always_comb begin
        w_next_count = r_count;
        w_next_tally = r_tally;
        w_next_pulse = 1'b0;
        if (restart) begin
            w_next_count = ZERO;
            w_next_tally = '0;
        end else if (clear) begin
            w_next_count = ZERO;
            w_next_tally = '0;
        end else if (load) begin
            w_next_count = load_val;
        end else if (count_enable) begin
            w_next_count = w_step_count;
            w_next_pulse = w_step_wrap;
            if (w_step_wrap && (r_tally != TALLY_MAX)) begin
                w_next_tally = r_tally + WRAP_W'(1);
            end
        end
        // Flag tracks the value about to be registered; restart forces it low
        w_next_flag = restart ? 1'b0 : (w_next_count == w_terminal);
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_count <= '0;
            r_flag  <= 1'b0;
            r_pulse <= 1'b0;
            r_tally <= '0;
        end else begin
            r_count <= w_next_count;
            r_flag  <= w_next_flag;
            r_pulse <= w_next_pulse;
            r_tally <= w_next_tally;
        end
    end

    assign count_out      = r_count;
    assign rollover_flag  = r_flag;
    assign rollover_pulse = r_pulse;
    assign wrap_count     = r_tally;

endmodule

// File: tb/tb_flex_counter_mode.sv
// Bench for flex_counter_mode: directed vector table, a small-tally instance,
// asynchronous reset check and randomized stimulus against a reference model.
module tb_flex_counter_mode;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       n_rst;
    logic       restart, clear, load, count_enable, up_down, saturate;
    logic [3:0] load_val, rollover_val;
    logic [3:0] count_out;
    logic       rollover_flag, rollover_pulse;
    logic [3:0] wrap_count;

    logic       b_restart, b_clear, b_load, b_en, b_ud, b_sat;
    logic [3:0] b_lv, b_rv;
    logic [3:0] b_count;
    logic       b_flag, b_pulse;
    logic [1:0] b_tally;

    flex_counter_mode #(.SIZE(4), .WRAP_W(4)) dut (
        .clk(clk), .n_rst(n_rst), .restart(restart), .clear(clear), .load(load),
        .load_val(load_val), .count_enable(count_enable), .up_down(up_down),
        .saturate(saturate), .rollover_val(rollover_val), .count_out(count_out),
        .rollover_flag(rollover_flag), .rollover_pulse(rollover_pulse),
        .wrap_count(wrap_count)
    );

    flex_counter_mode #(.SIZE(4), .WRAP_W(2)) dut_small (
        .clk(clk), .n_rst(n_rst), .restart(b_restart), .clear(b_clear), .load(b_load),
        .load_val(b_lv), .count_enable(b_en), .up_down(b_ud),
        .saturate(b_sat), .rollover_val(b_rv), .count_out(b_count),
        .rollover_flag(b_flag), .rollover_pulse(b_pulse),
        .wrap_count(b_tally)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rs, cl, ld;
        logic [3:0] lv;
        logic       en, ud, sat;
        logic [3:0] rv;
        int         e_cnt, e_flag, e_pulse, e_tally;
    } vec_t;

    vec_t vecs[$];

    // Reference model state
    int m_cnt, m_flag, m_pulse, m_tally;

    function automatic vec_t mk(logic rs, logic cl, logic ld, int lv, logic en, logic ud,
                                logic sat, int rv, int c, int f, int p, int t);
        vec_t v;
        v.rs = rs; v.cl = cl; v.ld = ld; v.lv = lv[3:0];
        v.en = en; v.ud = ud; v.sat = sat; v.rv = rv[3:0];
        v.e_cnt = c; v.e_flag = f; v.e_pulse = p; v.e_tally = t;
        return v;
    endfunction

    task automatic check_val(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(string tag, int c, int f, int p, int t);
        check_val({tag, ".count"}, int'(count_out), c);
        check_val({tag, ".flag"},  int'(rollover_flag), f);
        check_val({tag, ".pulse"}, int'(rollover_pulse), p);
        check_val({tag, ".tally"}, int'(wrap_count), t);
    endtask

    task automatic drive(logic rs, logic cl, logic ld, logic [3:0] lv, logic en,
                         logic ud, logic sat, logic [3:0] rv);
        restart = rs; clear = cl; load = ld; load_val = lv;
        count_enable = en; up_down = ud; saturate = sat; rollover_val = rv;
        @(posedge clk);
        #1;
    endtask

    // Model: apply the next-state rules arithmetically to integer state.
    task automatic model_step(logic rs, logic cl, logic ld, int lv, logic en,
                              logic ud, logic sat, int rv, int tmax);
        int term;
        term = ud ? rv : 1;
        m_pulse = 0;
        if (rs) begin
            m_cnt = 0; m_tally = 0;
        end else if (cl) begin
            m_cnt = 0; m_tally = 0;
        end else if (ld) begin
            m_cnt = lv;
        end else if (en && rv != 0) begin
            if (ud) begin
                if (m_cnt >= rv) begin
                    if (!sat) begin m_cnt = 1; m_pulse = 1; end
                end else m_cnt = m_cnt + 1;
            end else begin
                if (m_cnt == 1) begin
                    if (!sat) begin m_cnt = rv; m_pulse = 1; end
                end else if (m_cnt == 0 || m_cnt > rv) m_cnt = rv;
                else m_cnt = m_cnt - 1;
            end
        end
        if (m_pulse == 1 && m_tally < tmax) m_tally = m_tally + 1;
        m_flag = rs ? 0 : ((m_cnt == term) ? 1 : 0);
    endtask

    initial begin
        int exp_small_tally[6];
        int exp_small_pulse[6];
        vec_t v;
        logic rs, cl, ld, en, ud, sat;
        logic [3:0] lv, rv;

        exp_small_tally = '{0, 1, 2, 3, 3, 3};
        exp_small_pulse = '{0, 1, 1, 1, 1, 1};

        // Up/wrap rv=3, 8 enables from reset
        vecs.push_back(mk(0,0,0,0,1,1,0,3, 1,0,0,0));
        vecs.push_back(mk(0,0,0,0,1,1,0,3, 2,0,0,0));
        vecs.push_back(mk(0,0,0,0,1,1,0,3, 3,1,0,0));
        vecs.push_back(mk(0,0,0,0,1,1,0,3, 1,0,1,1));
        vecs.push_back(mk(0,0,0,0,1,1,0,3, 2,0,0,1));
        vecs.push_back(mk(0,0,0,0,1,1,0,3, 3,1,0,1));
        vecs.push_back(mk(0,0,0,0,1,1,0,3, 1,0,1,2));
        vecs.push_back(mk(0,0,0,0,1,1,0,3, 2,0,0,2));
        vecs.push_back(mk(1,0,0,0,0,1,0,3, 0,0,0,0));
        // Up/saturate rv=5, 9 enables
        vecs.push_back(mk(0,0,0,0,1,1,1,5, 1,0,0,0));
        vecs.push_back(mk(0,0,0,0,1,1,1,5, 2,0,0,0));
        vecs.push_back(mk(0,0,0,0,1,1,1,5, 3,0,0,0));
        vecs.push_back(mk(0,0,0,0,1,1,1,5, 4,0,0,0));
        vecs.push_back(mk(0,0,0,0,1,1,1,5, 5,1,0,0));
        vecs.push_back(mk(0,0,0,0,1,1,1,5, 5,1,0,0));
        vecs.push_back(mk(0,0,0,0,1,1,1,5, 5,1,0,0));
        vecs.push_back(mk(0,0,0,0,1,1,1,5, 5,1,0,0));
        vecs.push_back(mk(0,0,0,0,1,1,1,5, 5,1,0,0));
        vecs.push_back(mk(1,0,0,0,0,1,0,5, 0,0,0,0));
        // Down/wrap rv=4, 9 enables from 0
        vecs.push_back(mk(0,0,0,0,1,0,0,4, 4,0,0,0));
        vecs.push_back(mk(0,0,0,0,1,0,0,4, 3,0,0,0));
        vecs.push_back(mk(0,0,0,0,1,0,0,4, 2,0,0,0));
        vecs.push_back(mk(0,0,0,0,1,0,0,4, 1,1,0,0));
        vecs.push_back(mk(0,0,0,0,1,0,0,4, 4,0,1,1));
        vecs.push_back(mk(0,0,0,0,1,0,0,4, 3,0,0,1));
        vecs.push_back(mk(0,0,0,0,1,0,0,4, 2,0,0,1));
        vecs.push_back(mk(0,0,0,0,1,0,0,4, 1,1,0,1));
        vecs.push_back(mk(0,0,0,0,1,0,0,4, 4,0,1,2));
        // Pulse drops when idle
        vecs.push_back(mk(0,0,0,0,0,0,0,4, 4,0,0,2));
        // Priority
        vecs.push_back(mk(1,1,1,7,1,1,0,3, 0,0,0,0));
        vecs.push_back(mk(0,1,1,7,1,1,0,3, 0,0,0,0));
        vecs.push_back(mk(0,0,1,7,1,1,0,3, 7,0,0,0));
        // Loaded above rv: next up step wraps to 1
        vecs.push_back(mk(0,0,0,0,1,1,0,3, 1,0,1,1));
        // Loaded above rv: next down step reloads rv without event
        vecs.push_back(mk(0,0,1,9,0,0,0,5, 9,0,0,1));
        vecs.push_back(mk(0,0,0,0,1,0,0,5, 5,0,0,1));
        // rv=0 ignores enable
        vecs.push_back(mk(0,0,0,0,1,1,0,0, 5,0,0,1));
        // Load equal to terminal raises flag; down/saturate holds at 1
        vecs.push_back(mk(0,0,1,1,0,0,1,5, 1,1,0,1));
        vecs.push_back(mk(0,0,0,0,1,0,1,5, 1,1,0,1));
        vecs.push_back(mk(0,0,0,0,0,0,1,5, 1,1,0,1));
        // Clear with up/rv=0: count 0 equals terminal
        vecs.push_back(mk(0,1,0,0,0,1,0,0, 0,1,0,0));

        n_rst = 1'b0;
        restart = 0; clear = 0; load = 0; load_val = 0;
        count_enable = 0; up_down = 0; saturate = 0; rollover_val = 0;
        b_restart = 0; b_clear = 0; b_load = 0; b_lv = 0;
        b_en = 0; b_ud = 0; b_sat = 0; b_rv = 0;

        #12;
        check_all("reset", 0, 0, 0, 0);
        @(negedge clk);
        n_rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            drive(v.rs, v.cl, v.ld, v.lv, v.en, v.ud, v.sat, v.rv);
            $display("vec %0d: count=%0d flag=%0d pulse=%0d tally=%0d", i,
                     count_out, rollover_flag, rollover_pulse, wrap_count);
            check_all($sformatf("vec%0d", i), v.e_cnt, v.e_flag, v.e_pulse, v.e_tally);
        end

        // Tally saturation on the 2-bit-tally instance: up/wrap rv=1
        b_en = 1; b_ud = 1; b_sat = 0; b_rv = 1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            $display("small %0d: count=%0d pulse=%0d tally=%0d", i, b_count, b_pulse, b_tally);
            check_val($sformatf("small%0d.count", i), int'(b_count), 1);
            check_val($sformatf("small%0d.pulse", i), int'(b_pulse), exp_small_pulse[i]);
            check_val($sformatf("small%0d.tally", i), int'(b_tally), exp_small_tally[i]);
        end
        b_en = 0;

        // Async reset mid-count
        drive(1, 0, 0, 0, 0, 1, 0, 3);
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 1, 1, 0, 3);
        $display("pre-reset: count=%0d flag=%0d tally=%0d", count_out, rollover_flag, wrap_count);
        check_all("prerst", 2, 0, 0, 1);
        #3;
        n_rst = 1'b0;
        #1;
        $display("async reset: count=%0d flag=%0d tally=%0d", count_out, rollover_flag, wrap_count);
        check_all("asyncrst", 0, 0, 0, 0);
        @(negedge clk);
        n_rst = 1'b1;
        drive(0, 0, 0, 0, 1, 1, 0, 3);
        check_all("resume", 1, 0, 0, 0);

        // Randomized stimulus against the model
        drive(1, 0, 0, 0, 0, 1, 0, 3);
        m_cnt = 0; m_flag = 0; m_pulse = 0; m_tally = 0;
        rv = 4'd6;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 3))
                    0: rv = 4'd0;
                    1: rv = 4'd1;
                    default: rv = 4'($urandom_range(0, 15));
                endcase
            end
            rs  = ($urandom_range(0, 59) == 0);
            cl  = ($urandom_range(0, 29) == 0);
            ld  = ($urandom_range(0, 9) == 0);
            lv  = 4'($urandom_range(0, 15));
            en  = ($urandom_range(0, 3) != 0);
            ud  = ($urandom_range(0, 3) != 0) ? up_down : ~up_down;
            sat = ($urandom_range(0, 7) == 0) ? ~saturate : saturate;
            model_step(rs, cl, ld, int'(lv), en, ud, sat, int'(rv), 15);
            drive(rs, cl, ld, lv, en, ud, sat, rv);
            $display("rand %0d: rs=%0d cl=%0d ld=%0d lv=%0d en=%0d ud=%0d sat=%0d rv=%0d -> count=%0d flag=%0d pulse=%0d tally=%0d",
                     i, rs, cl, ld, lv, en, ud, sat, rv,
                     count_out, rollover_flag, rollover_pulse, wrap_count);
            check_all($sformatf("rand%0d", i), m_cnt, m_flag, m_pulse, m_tally);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
